// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-core data-memory arbiter.
//   arb_state_t  : arbiter FSM state encodings
//   CORE0/CORE1  : core index constants used for owner, pointer and winner
//   other_core() : index of the core that is not the given one
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

    function automatic logic other_core(input logic core);
        return ~core;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Winner selection for the two-core arbiter (purely combinational).
// Ports:
//   req[1:0]   : per-core request, already masked by the caller where needed
//   ptr        : round-robin pointer, the core favoured when both request
//   locked     : a lock is in force; only lock_owner may be granted
//   lock_owner : core holding the lock
//   valid      : some core is granted
//   winner     : index of the granted core
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       locked,
    input  logic       lock_owner,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        if (locked) begin
            // The other core stays stalled even if it is the only requester.
            valid  = req[lock_owner];
            winner = lock_owner;
        end else if (req[CORE0] && req[CORE1]) begin
            valid  = 1'b1;
            winner = ptr;
        end else if (req[CORE0]) begin
            valid  = 1'b1;
            winner = CORE0;
        end else if (req[CORE1]) begin
            valid  = 1'b1;
            winner = CORE1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-core arbiter in front of a single shared DataMemory.
// Each access runs IDLE -> ISSUE -> DONE: the winner's command is latched into
// the mem_* registers, the strobe is driven for the ISSUE cycle, read data is
// captured at the end of ISSUE, and the owner's ack pulses during DONE. From
// DONE the other core can be taken straight into ISSUE, giving one access per
// two cycles under contention.
// Ports:
//   Clk, Reset                     : clock, synchronous active-high reset
//   cN_req/read/write/half/byte    : core N command, held until cN_ack
//   cN_lock                        : hold-grant hint (lock feature only)
//   cN_addr/wdata                  : core N address and write data
//   cN_ack, cN_rdata               : completion pulse and read data
//   mem_*                          : registered command to DataMemory
//   mem_rdata                      : combinational read data from DataMemory
// Build option: define MEM_ARB_LOCK_EN to enable lock handling; otherwise the
// cN_lock inputs are ignored and no lock state exists.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              c0_req,
    input  logic              c0_read,
    input  logic              c0_write,
    input  logic              c0_half,
    input  logic              c0_byte,
    input  logic              c0_lock,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    input  logic              c1_req,
    input  logic              c1_read,
    input  logic              c1_write,
    input  logic              c1_half,
    input  logic              c1_byte,
    input  logic              c1_lock,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c0_ack,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c1_ack,
    output logic [DATA_W-1:0] c1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_half,
    output logic              mem_byte,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Per-core command views so the winner can be selected by index.
    logic [1:0]        req_vec;
    logic [1:0]        read_vec;
    logic [1:0]        write_vec;
    logic [1:0]        half_vec;
    logic [1:0]        byte_vec;
    logic [ADDR_W-1:0] addr_vec  [2];
    logic [DATA_W-1:0] wdata_vec [2];

    assign req_vec      = {c1_req,   c0_req};
    assign read_vec     = {c1_read,  c0_read};
    assign write_vec    = {c1_write, c0_write};
    assign half_vec     = {c1_half,  c0_half};
    assign byte_vec     = {c1_byte,  c0_byte};
    assign addr_vec[0]  = c0_addr;
    assign addr_vec[1]  = c1_addr;
    assign wdata_vec[0] = c0_wdata;
    assign wdata_vec[1] = c1_wdata;

    arb_state_t        state_reg;
    logic              ptr_reg;
    logic              owner_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic              mem_half_reg;
    logic              mem_byte_reg;
    logic [1:0]        ack_reg;
    logic [DATA_W-1:0] rdata_reg [2];

`ifdef MEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    logic [1:0]        lock_vec;
    logic              cmd_lock_reg;
    logic              locked_reg;
    logic [CNT_W-1:0]  lock_cnt_reg;
    assign lock_vec = {c1_lock, c0_lock};
`else
    logic unused_lock;
    assign unused_lock = c0_lock ^ c1_lock;
`endif

    logic [1:0] pick_req;
    logic       pick_locked;
    logic       pick_valid;
    logic       pick_winner;
    logic       take_cmd;

    // In DONE the owner's request is still up (it is seeing its ack), so it
    // is masked; the lock decision there uses the lock bit of the access that
    // is completing now.
    always_comb begin
        pick_req    = req_vec;
        pick_locked = 1'b0;
        if (state_reg == ST_DONE) begin
            pick_req[owner_reg] = 1'b0;
        end
`ifdef MEM_ARB_LOCK_EN
        pick_locked = (state_reg == ST_DONE) ? cmd_lock_reg : locked_reg;
`endif
    end

    mem_arb_rr_pick u_pick (
        .req        (pick_req),
        .ptr        (ptr_reg),
        .locked     (pick_locked),
        .lock_owner (owner_reg),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign take_cmd = pick_valid && (state_reg == ST_IDLE || state_reg == ST_DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= CORE0;
            owner_reg     <= CORE0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_half_reg  <= 1'b0;
            mem_byte_reg  <= 1'b0;
            ack_reg       <= '0;
            rdata_reg[0]  <= '0;
            rdata_reg[1]  <= '0;
`ifdef MEM_ARB_LOCK_EN
            cmd_lock_reg  <= 1'b0;
            locked_reg    <= 1'b0;
            lock_cnt_reg  <= '0;
`endif
        end else begin
            ack_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg <= ST_ISSUE;
`ifdef MEM_ARB_LOCK_EN
                        lock_cnt_reg <= '0;
                    end else if (locked_reg) begin
                        // Owner idle while holding the lock: release after
                        // LOCK_TIMEOUT consecutive idle cycles.
                        if (lock_cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            locked_reg   <= 1'b0;
                            lock_cnt_reg <= '0;
                            ptr_reg      <= other_core(owner_reg);
                        end else begin
                            lock_cnt_reg <= lock_cnt_reg + 1'b1;
                        end
`endif
                    end
                end
                ST_ISSUE: begin
                    // Strobe lasts exactly this one cycle; ack shows in DONE.
                    mem_read_reg  <= 1'b0;
                    mem_write_reg <= 1'b0;
                    if (mem_read_reg) begin
                        rdata_reg[owner_reg] <= mem_rdata;
                    end
                    ack_reg[owner_reg] <= 1'b1;
                    state_reg          <= ST_DONE;
                end
                ST_DONE: begin
                    ptr_reg   <= other_core(owner_reg);
                    state_reg <= pick_valid ? ST_ISSUE : ST_IDLE;
`ifdef MEM_ARB_LOCK_EN
                    locked_reg   <= cmd_lock_reg;
                    lock_cnt_reg <= '0;
`endif
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (take_cmd) begin
                owner_reg     <= pick_winner;
                mem_addr_reg  <= addr_vec[pick_winner];
                mem_wdata_reg <= wdata_vec[pick_winner];
                mem_read_reg  <= read_vec[pick_winner];
                mem_write_reg <= write_vec[pick_winner];
                mem_half_reg  <= half_vec[pick_winner];
                mem_byte_reg  <= byte_vec[pick_winner];
`ifdef MEM_ARB_LOCK_EN
                cmd_lock_reg  <= lock_vec[pick_winner];
`endif
            end
        end
    end

    assign c0_ack    = ack_reg[0];
    assign c1_ack    = ack_reg[1];
    assign c0_rdata  = rdata_reg[0];
    assign c1_rdata  = rdata_reg[1];
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_half  = mem_half_reg;
    assign mem_byte  = mem_byte_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter. Stimulus pushes the expected response
// of each issued command into a per-core queue; a monitor pops and compares on
// every ack (read data, ack cycle, strobe of the preceding cycle, latched
// address/size/write data).
`timescale 1ns/1ps
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c0_req, c0_read, c0_write, c0_half, c0_byte, c0_lock;
    logic [31:0] c0_addr, c0_wdata;
    logic        c1_req, c1_read, c1_write, c1_half, c1_byte, c1_lock;
    logic [31:0] c1_addr, c1_wdata;
    logic        c0_ack, c1_ack;
    logic [31:0] c0_rdata, c1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_half, mem_byte;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_TIMEOUT(4)) dut (
        .Clk(clk), .Reset(rst),
        .c0_req(c0_req), .c0_read(c0_read), .c0_write(c0_write),
        .c0_half(c0_half), .c0_byte(c0_byte), .c0_lock(c0_lock),
        .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c1_req(c1_req), .c1_read(c1_read), .c1_write(c1_write),
        .c1_half(c1_half), .c1_byte(c1_byte), .c1_lock(c1_lock),
        .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c0_ack(c0_ack), .c0_rdata(c0_rdata),
        .c1_ack(c1_ack), .c1_rdata(c1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_half(mem_half), .mem_byte(mem_byte),
        .mem_rdata(mem_rdata)
    );

    // DataMemory model: 0x10 holds 0xDEADBEEF, everything else reads C0DE_<addr>.
    assign mem_rdata = (mem_addr == 32'h10) ? 32'hDEADBEEF
                                            : (32'hC0DE0000 | {16'h0, mem_addr[15:0]});

    typedef struct {
        logic        rd, wr, hf, by, lk;
        logic [31:0] addr, wdata, exp_rdata;
        int          off;
    } cmd_t;

    typedef struct {
        cmd_t cmd;
        int   cyc;
    } exp_t;

    cmd_t stim0[$], stim1[$];
    exp_t exp0[$], exp1[$];

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int strobe_cnt  = 0;
    int exp_strobes = 0;

    logic        prev_rd, prev_wr, prev_hf, prev_by;
    logic [31:0] prev_addr, prev_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic cmd_t mk(input logic rd, input logic wr, input logic hf,
                                input logic by, input logic lk, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input int off);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.hf = hf; c.by = by; c.lk = lk;
        c.addr = addr; c.wdata = wdata; c.exp_rdata = exp_rdata; c.off = off;
        return c;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input int core, input cmd_t c, input int t0);
        exp_t e;
        e.cmd = c;
        e.cyc = t0 + c.off;
        if (c.rd || c.wr) exp_strobes++;
        $display("issue c%0d rd=%0b wr=%0b addr=%h wdata=%h lock=%0b -> ack@%0d rdata=%h",
                 core, c.rd, c.wr, c.addr, c.wdata, c.lk, e.cyc, c.exp_rdata);
        if (core == 0) begin
            c0_read = c.rd; c0_write = c.wr; c0_half = c.hf; c0_byte = c.by;
            c0_lock = c.lk; c0_addr = c.addr; c0_wdata = c.wdata; c0_req = 1'b1;
            exp0.push_back(e);
        end else begin
            c1_read = c.rd; c1_write = c.wr; c1_half = c.hf; c1_byte = c.by;
            c1_lock = c.lk; c1_addr = c.addr; c1_wdata = c.wdata; c1_req = 1'b1;
            exp1.push_back(e);
        end
    endtask

    // Call at posedge+1. Each core presents its next command as soon as it
    // sees its ack, and drops req when its list is exhausted.
    task automatic run_phase(input int budget);
        int t0;
        t0 = cyc;
        if (stim0.size() > 0) present(0, stim0.pop_front(), t0);
        if (stim1.size() > 0) present(1, stim1.pop_front(), t0);
        for (int n = 0; n < budget && (c0_req || c1_req); n++) begin
            @(negedge clk);
            if (c0_ack) begin
                if (stim0.size() > 0) present(0, stim0.pop_front(), t0);
                else c0_req = 1'b0;
            end
            if (c1_ack) begin
                if (stim1.size() > 0) present(1, stim1.pop_front(), t0);
                else c1_req = 1'b0;
            end
        end
        check("phase_drained", {30'd0, c0_req, c1_req}, 32'd0);
        c0_req = 1'b0;
        c1_req = 1'b0;
        sync();
        sync();
    endtask

    task automatic score(input int core, input logic [31:0] rdata);
        exp_t e;
        int   sz;
        string p;
        p  = $sformatf("c%0d", core);
        sz = (core == 0) ? exp0.size() : exp1.size();
        check({p, "_ack_expected"}, 32'(sz != 0), 32'd1);
        if (sz == 0) return;
        if (core == 0) e = exp0.pop_front();
        else           e = exp1.pop_front();
        $display("ack   c%0d cycle=%0d rdata=%h (expected cycle=%0d rdata=%h)",
                 core, cyc, rdata, e.cyc, e.cmd.exp_rdata);
        check({p, "_rdata"}, rdata, e.cmd.exp_rdata);
        check({p, "_ack_cycle"}, 32'(cyc), 32'(e.cyc));
        check({p, "_strobe"}, {28'd0, prev_rd, prev_wr, mem_read, mem_write},
              {28'd0, e.cmd.rd, e.cmd.wr, 2'b00});
        check({p, "_addr"}, prev_addr, e.cmd.addr);
        check({p, "_size"}, {30'd0, prev_hf, prev_by}, {30'd0, e.cmd.hf, e.cmd.by});
        if (e.cmd.wr) check({p, "_wdata"}, prev_wdata, e.cmd.wdata);
    endtask

    // Monitor: compares on every ack, then records this cycle's memory command.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (c0_ack || c1_ack) check("ack_onehot", {31'd0, c0_ack & c1_ack}, 32'd0);
                if (c0_ack) score(0, c0_rdata);
                if (c1_ack) score(1, c1_rdata);
            end
            if (mem_read || mem_write) strobe_cnt++;
            prev_rd    = mem_read;
            prev_wr    = mem_write;
            prev_hf    = mem_half;
            prev_by    = mem_byte;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        c0_req = 0; c0_read = 0; c0_write = 0; c0_half = 0; c0_byte = 0; c0_lock = 0;
        c1_req = 0; c1_read = 0; c1_write = 0; c1_half = 0; c1_byte = 0; c1_lock = 0;
        c0_addr = '0; c0_wdata = '0; c1_addr = '0; c1_wdata = '0;
        repeat (3) sync();
        rst = 1'b0;

        // Reset state
        check("rst_mem_ctrl", {28'd0, mem_read, mem_write, mem_half, mem_byte}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_acks", {30'd0, c0_ack, c1_ack}, 32'd0);
        check("rst_c0_rdata", c0_rdata, 32'd0);
        check("rst_c1_rdata", c1_rdata, 32'd0);
        sync();

        // Single read by c0
        stim0.push_back(mk(1, 0, 0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2));
        run_phase(20);

        // Reset while a c1 write is in ISSUE: abandoned, no ack, pointer back to c0
        c1_read = 0; c1_write = 1; c1_half = 0; c1_byte = 1; c1_lock = 0;
        c1_addr = 32'h30; c1_wdata = 32'h11223344; c1_req = 1'b1;
        exp_strobes++;
        sync();
        check("mid_issue_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b1;
        sync();
        check("mid_rst_write", {31'd0, mem_write}, 32'd0);
        check("mid_rst_c1_ack", {31'd0, c1_ack}, 32'd0);
        check("mid_rst_c0_rdata", c0_rdata, 32'd0);
        rst = 1'b0;
        c1_req = 1'b0;
        sync();
        sync();

        // Simultaneous after reset: c0 write first, then c1 read
        stim0.push_back(mk(0, 1, 1, 0, 0, 32'h20, 32'hCAFEF00D, 32'h0, 2));
        stim1.push_back(mk(1, 0, 0, 0, 0, 32'h24, 32'h0, 32'hC0DE0024, 4));
        run_phase(30);

        // Fairness: both cores continuously, 10 accesses, including no-strobe ones
        stim0.push_back(mk(1, 0, 0, 0, 0, 32'h40, 32'h0,  32'hC0DE0040, 2));
        stim0.push_back(mk(0, 1, 0, 1, 0, 32'h41, 32'hAB, 32'hC0DE0040, 6));
        stim0.push_back(mk(1, 0, 0, 0, 0, 32'h10, 32'h0,  32'hDEADBEEF, 10));
        stim0.push_back(mk(0, 0, 0, 0, 0, 32'h48, 32'h0,  32'hDEADBEEF, 14));
        stim0.push_back(mk(1, 0, 0, 0, 0, 32'h44, 32'h0,  32'hC0DE0044, 18));
        stim1.push_back(mk(1, 0, 0, 0, 0, 32'h80, 32'h0,    32'hC0DE0080, 4));
        stim1.push_back(mk(0, 1, 1, 0, 0, 32'h82, 32'h1234, 32'hC0DE0080, 8));
        stim1.push_back(mk(0, 0, 0, 0, 0, 32'h8C, 32'h0,    32'hC0DE0080, 12));
        stim1.push_back(mk(1, 0, 0, 0, 0, 32'h84, 32'h0,    32'hC0DE0084, 16));
        stim1.push_back(mk(1, 0, 0, 0, 0, 32'h88, 32'h0,    32'hC0DE0088, 20));
        run_phase(60);

        // c0 issues lock 1,1,0 while c1 waits
`ifdef MEM_ARB_LOCK_EN
        stim0.push_back(mk(1, 0, 0, 0, 1, 32'h50, 32'h0,        32'hC0DE0050, 2));
        stim0.push_back(mk(0, 1, 0, 0, 1, 32'h54, 32'h55AA55AA, 32'hC0DE0050, 5));
        stim0.push_back(mk(1, 0, 0, 0, 0, 32'h58, 32'h0,        32'hC0DE0058, 8));
        stim1.push_back(mk(1, 0, 0, 0, 0, 32'h60, 32'h0,        32'hC0DE0060, 10));
`else
        stim0.push_back(mk(1, 0, 0, 0, 1, 32'h50, 32'h0,        32'hC0DE0050, 2));
        stim0.push_back(mk(0, 1, 0, 0, 1, 32'h54, 32'h55AA55AA, 32'hC0DE0050, 6));
        stim0.push_back(mk(1, 0, 0, 0, 0, 32'h58, 32'h0,        32'hC0DE0058, 9));
        stim1.push_back(mk(1, 0, 0, 0, 0, 32'h60, 32'h0,        32'hC0DE0060, 4));
`endif
        run_phase(40);

        // Locked access then c0 idle: c1 waits out LOCK_TIMEOUT idle cycles
`ifdef MEM_ARB_LOCK_EN
        stim0.push_back(mk(1, 0, 0, 0, 1, 32'h70, 32'h0, 32'hC0DE0070, 2));
        stim1.push_back(mk(1, 0, 0, 0, 0, 32'h74, 32'h0, 32'hC0DE0074, 9));
`else
        stim0.push_back(mk(1, 0, 0, 0, 1, 32'h70, 32'h0, 32'hC0DE0070, 4));
        stim1.push_back(mk(1, 0, 0, 0, 0, 32'h74, 32'h0, 32'hC0DE0074, 2));
`endif
        run_phase(40);

        check("c0_pending", 32'(exp0.size()), 32'd0);
        check("c1_pending", 32'(exp1.size()), 32'd0);
        check("strobe_count", 32'(strobe_cnt), 32'(exp_strobes));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
